// File: rtl/serial_adder.sv
// Bit-serial adder: one sum bit per clock, LSB first, built from two half adders and a carry flop.
// Optional signed-overflow output `ovf` is enabled by defining SERIAL_ADDER_OVF_EN.

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] sum_r;
  logic [CNT_W-1:0] cnt_r;
  logic             c_r;
  logic             cout_r;
  logic             last_bit_s;
  logic             in_ready_s;
  logic             out_valid_s;
  logic             busy_s;

  // Full adder for the current bit position: two half adders plus an OR.
  logic ha0_s_s;
  logic ha0_c_s;
  logic bit_s_s;
  logic ha1_c_s;
  logic c_next_s;

  half_adder u_ha0 (
    .a (a_sh_r[0]),
    .b (b_sh_r[0]),
    .s (ha0_s_s),
    .c (ha0_c_s)
  );

  half_adder u_ha1 (
    .a (ha0_s_s),
    .b (c_r),
    .s (bit_s_s),
    .c (ha1_c_s)
  );

  assign c_next_s   = ha0_c_s | ha1_c_s;
  assign last_bit_s = (state_r == SHIFT) && (cnt_r == LAST_BIT);

  // Next-state logic and handshake decode from the current state.
  always_comb begin
    next_state_s = state_r;
    in_ready_s   = 1'b0;
    out_valid_s  = 1'b0;
    busy_s       = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready_s = 1'b1;
        if (in_valid) begin
          next_state_s = SHIFT;
        end else begin
          next_state_s = IDLE;
        end
      end
      SHIFT: begin
        busy_s = 1'b1;
        if (cnt_r == LAST_BIT) begin
          next_state_s = DONE;
        end else begin
          next_state_s = SHIFT;
        end
      end
      DONE: begin
        busy_s      = 1'b1;
        out_valid_s = 1'b1;
        if (out_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Operand capture, bit-serial shifting and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh_r <= {WIDTH{1'b0}};
      b_sh_r <= {WIDTH{1'b0}};
      sum_r  <= {WIDTH{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
      c_r    <= 1'b0;
      cout_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_sh_r <= a;
            b_sh_r <= b;
            c_r    <= cin;
            cnt_r  <= {CNT_W{1'b0}};
          end
        end
        SHIFT: begin
          sum_r  <= {bit_s_s, sum_r[WIDTH-1:1]};
          a_sh_r <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r <= {1'b0, b_sh_r[WIDTH-1:1]};
          c_r    <= c_next_s;
          cnt_r  <= cnt_r + CNT_ONE;
          if (last_bit_s) begin
            cout_r <= c_next_s;
          end
        end
        DONE: begin
          sum_r  <= sum_r;
          cout_r <= cout_r;
        end
        default: begin
          cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_r;

  // On the last bit c_r is the carry into the MSB and c_next_s the carry out of it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (last_bit_s) begin
      ovf_r <= c_r ^ c_next_s;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign ovf = ovf_r;
`endif

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign busy      = busy_s;
  assign sum       = sum_r;
  assign cout      = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed and random ops at WIDTH=8, exhaustive at WIDTH=2.
// Expected results come from plain integer addition of the operands.

module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  int         tests = 0;
  int         fails = 0;

  logic       in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8, busy8;
  logic [7:0] a8, b8, sum8;
  logic       in_valid2, in_ready2, cin2, out_valid2, out_ready2, cout2, busy2;
  logic [1:0] a2, b2, sum2;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf8, ovf2;
`endif

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf8),
`endif
    .busy(busy8)
  );

  serial_adder #(.WIDTH(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .cin(cin2), .out_valid(out_valid2), .out_ready(out_ready2),
    .sum(sum2), .cout(cout2),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf2),
`endif
    .busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One WIDTH=8 operation with `stall` cycles of backpressure in DONE.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic cv, input int stall);
    logic [8:0] exp;
    logic       exp_ovf;
    int         lat;
    exp     = {1'b0, av} + {1'b0, bv} + {8'd0, cv};
    exp_ovf = (av[7] == bv[7]) && (exp[7] != av[7]);
    chk("idle_ready", in_ready8, 1);
    in_valid8 = 1'b1; a8 = av; b8 = bv; cin8 = cv; out_ready8 = 1'b0;
    tick;
    lat = 0;
    while (!out_valid8 && lat < 40) begin
      chk("shift_in_ready", in_ready8, 0);
      chk("shift_busy", busy8, 1);
      in_valid8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
      tick;
      lat++;
    end
    chk("latency", lat, 8);
    chk("sum", sum8, exp[7:0]);
    chk("cout", cout8, exp[8]);
`ifdef SERIAL_ADDER_OVF_EN
    chk("ovf", ovf8, exp_ovf);
`endif
    for (int i = 0; i < stall; i++) begin
      in_valid8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      tick;
      chk("hold_sum", sum8, exp[7:0]);
      chk("hold_cout", cout8, exp[8]);
      chk("hold_in_ready", in_ready8, 0);
      chk("hold_out_valid", out_valid8, 1);
    end
    in_valid8 = 1'b1;
    out_ready8 = 1'b1;
    tick;
    out_ready8 = 1'b0;
    chk("consumed_valid", out_valid8, 0);
    chk("no_turnaround", busy8, 0);
    in_valid8 = 1'b0;
  endtask

  // One WIDTH=2 operation with a random number of stall cycles.
  task automatic op2(input logic [1:0] av, input logic [1:0] bv, input logic cv);
    logic [2:0] exp;
    int         lat;
    exp = {1'b0, av} + {1'b0, bv} + {2'd0, cv};
    in_valid2 = 1'b1; a2 = av; b2 = bv; cin2 = cv;
    out_ready2 = 1'b0;
    tick;
    in_valid2 = 1'b0;
    lat = 0;
    while (!out_valid2 && lat < 20) begin
      tick;
      lat++;
    end
    chk("w2_latency", lat, 2);
    for (int i = 0; i < $urandom_range(0, 3); i++) begin
      tick;
    end
    chk("w2_sum", sum2, exp[1:0]);
    chk("w2_cout", cout2, exp[2]);
    out_ready2 = 1'b1;
    tick;
    out_ready2 = 1'b0;
    chk("w2_idle", in_ready2, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; out_ready8 = 1'b0;
    in_valid2 = 1'b0; a2 = 2'b00; b2 = 2'b00; cin2 = 1'b0; out_ready2 = 1'b0;
    tick;
    tick;
    chk("rst_sum", sum8, 0);
    chk("rst_cout", cout8, 0);
    chk("rst_out_valid", out_valid8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_in_ready", in_ready8, 1);
    chk("rst_w2_busy", busy2, 0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst_ovf", ovf8, 0);
`endif
    rst_n = 1'b1;
    tick;

    op8(8'h00, 8'h00, 1'b0, 0);
    op8(8'hFF, 8'h01, 1'b0, 0);
    op8(8'h5A, 8'h33, 1'b1, 0);
    op8(8'hC3, 8'h3C, 1'b1, 5);

    // Reset after three SHIFT edges discards the operation.
    in_valid8 = 1'b1; a8 = 8'h37; b8 = 8'h55; cin8 = 1'b1;
    tick;
    in_valid8 = 1'b0;
    tick; tick; tick;
    rst_n = 1'b0;
    tick;
    chk("midrst_out_valid", out_valid8, 0);
    chk("midrst_sum", sum8, 0);
    chk("midrst_busy", busy8, 0);
    chk("midrst_cout", cout8, 0);
    rst_n = 1'b1;
    tick;
    op8(8'h10, 8'h20, 1'b0, 0);

    // Reset beats a simultaneous handshake.
    in_valid8 = 1'b1;
    rst_n = 1'b0;
    tick;
    chk("rst_prio_busy", busy8, 0);
    rst_n = 1'b1;
    in_valid8 = 1'b0;
    tick;

`ifdef SERIAL_ADDER_OVF_EN
    op8(8'h7F, 8'h01, 1'b0, 0);
    op8(8'h80, 8'h80, 1'b0, 0);
    op8(8'h01, 8'h01, 1'b0, 0);
`endif

    for (int i = 0; i < 20; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    for (int i = 0; i < 32; i++) begin
      logic [4:0] v;
      v = 5'(i);
      op2(v[4:3], v[2:1], v[0]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
